// File: rtl/sync_fifo_rr_sched.sv
// Frame-granular round-robin read scheduler: drains NUM_Q standard-mode FIFOs
// onto a single valid/ready stream without interleaving frames.
module sync_fifo_rr_sched #(
  parameter int NUM_Q = 4,
  parameter int WIDTH = 9,
  parameter int QID_W = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_Q-1:0]       Q_EMPTY,
  input  logic [NUM_Q*WIDTH-1:0] Q_DOUT,
  input  logic [NUM_Q-1:0]       Q_ENABLE,
  output logic [NUM_Q-1:0]       Q_RD_EN,
  output logic [WIDTH-2:0]       O_DATA,
  output logic                   O_LAST,
  output logic [QID_W-1:0]       O_QID,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic                   BUSY
);

  localparam int ENT_W = WIDTH + QID_W;

  typedef enum logic {ARB, XFER} state_t;

  state_t           state;
  logic [QID_W-1:0] grant;
  logic [QID_W-1:0] rr_ptr;
  logic [QID_W-1:0] pick;
  logic             pick_vld;
  logic [NUM_Q-1:0] elig;
  int               idx;

  logic             rd_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] word_p1;
  logic             last_p1;

  logic [ENT_W-1:0] buf_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;
  logic [2:0]       occ_sum;
  logic             credit_ok;

  assign elig = ~Q_EMPTY & Q_ENABLE;

  // Scan downward so the final hit is the first queue after rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_Q; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_Q;
      if (elig[idx]) begin
        pick     = QID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Stage p0: read issue; credit covers the word in flight plus buffered words.
  assign word_p1   = Q_DOUT[int'(grant)*WIDTH +: WIDTH];
  assign last_p1   = vld_p1 && word_p1[WIDTH-1];
  assign pop       = O_VALID && O_READY;
  assign push      = vld_p1;
  assign occ_sum   = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign credit_ok = occ_sum < 3'd2;
  assign rd_p0     = (state == XFER) && !Q_EMPTY[grant] && credit_ok && !last_p1;

  always_comb begin
    Q_RD_EN = '0;
    if (rd_p0) Q_RD_EN[grant] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB;
      rr_ptr <= QID_W'(NUM_Q - 1);
      grant  <= '0;
      vld_p1 <= 1'b0;
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      vld_p1 <= rd_p0;
      case (state)
        ARB: begin
          if (pick_vld) begin
            grant  <= pick;
            rr_ptr <= pick;
            state  <= XFER;
          end
        end
        XFER: begin
          if (last_p1) state <= ARB;
        end
        default: state <= ARB;
      endcase
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stage p1: FIFO DOUT lands in the output buffer tagged with its queue.
  always_ff @(posedge CLK) begin
    if (push) buf_mem[wr_ptr] <= {word_p1, grant};
  end

  assign head    = buf_mem[rd_ptr];
  assign O_VALID = (count != 2'd0);
  assign O_LAST  = O_VALID ? head[ENT_W-1] : 1'b0;
  assign O_DATA  = O_VALID ? head[ENT_W-2:QID_W] : '0;
  assign O_QID   = O_VALID ? head[QID_W-1:0] : '0;
  assign BUSY    = (state == XFER);

endmodule

// File: tb/tb_sync_fifo_rr_sched.sv
// Scoreboard bench for sync_fifo_rr_sched: a 4-queue and a 3-queue instance fed
// by behavioural standard-mode FIFOs.
module tb_sync_fifo_rr_sched;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [3:0]  a_empty, a_enable, a_rd;
  logic [35:0] a_dout;
  logic [7:0]  a_data;
  logic        a_last, a_valid, a_ready, a_busy;
  logic [1:0]  a_qid;

  logic [2:0]  b_empty, b_enable, b_rd;
  logic [26:0] b_dout;
  logic [7:0]  b_data;
  logic        b_last, b_valid, b_ready, b_busy;
  logic [1:0]  b_qid;

  sync_fifo_rr_sched #(.NUM_Q(4), .WIDTH(9), .QID_W(2)) u_a (
    .CLK(CLK), .RST(RST), .Q_EMPTY(a_empty), .Q_DOUT(a_dout), .Q_ENABLE(a_enable),
    .Q_RD_EN(a_rd), .O_DATA(a_data), .O_LAST(a_last), .O_QID(a_qid),
    .O_VALID(a_valid), .O_READY(a_ready), .BUSY(a_busy));

  sync_fifo_rr_sched #(.NUM_Q(3), .WIDTH(9), .QID_W(2)) u_b (
    .CLK(CLK), .RST(RST), .Q_EMPTY(b_empty), .Q_DOUT(b_dout), .Q_ENABLE(b_enable),
    .Q_RD_EN(b_rd), .O_DATA(b_data), .O_LAST(b_last), .O_QID(b_qid),
    .O_VALID(b_valid), .O_READY(b_ready), .BUSY(b_busy));

  // FIFO models: slots 0..3 feed u_a, slots 4..6 feed u_b.
  logic [8:0]  mf [7][$];
  logic [8:0]  mdout [7];
  logic [10:0] exp_a [$];
  logic [10:0] exp_b [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [3:0] cap_a_rd;
  logic [2:0] cap_b_rd;
  logic       cap_a_vld, cap_a_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      a_empty[i] = (mf[i].size() == 0);
      a_dout[i*9 +: 9] = mdout[i];
    end
    for (int i = 0; i < 3; i++) begin
      b_empty[i] = (mf[4+i].size() == 0);
      b_dout[i*9 +: 9] = mdout[4+i];
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cap_a_rd   = a_rd;
    cap_b_rd   = b_rd;
    cap_a_vld  = a_valid;
    cap_a_busy = a_busy;
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (cap_a_rd[i] && mf[i].size() > 0) mdout[i] = mf[i].pop_front();
    for (int i = 0; i < 3; i++)
      if (cap_b_rd[i] && mf[4+i].size() > 0) mdout[4+i] = mf[4+i].pop_front();
    refresh();
  endtask

  task automatic frame(input int bank, input int q, input int n,
                       input logic [7:0] base, input bit do_exp);
    logic [8:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(i == n-1), base + 8'(i)};
      mf[bank*4+q].push_back(w);
      if (do_exp) begin
        if (bank == 0) exp_a.push_back({2'(q), w});
        else           exp_b.push_back({2'(q), w});
      end
    end
    refresh();
  endtask

  task automatic do_reset(input bit check_zero);
    RST = 1'b1;
    tick();
    if (check_zero) begin
      chk("rst_o_valid", a_valid, 0);
      chk("rst_o_data",  a_data,  0);
      chk("rst_o_last",  a_last,  0);
      chk("rst_o_qid",   a_qid,   0);
      chk("rst_busy",    a_busy,  0);
      chk("rst_rd_en",   a_rd,    0);
    end
    tick();
    for (int i = 0; i < 7; i++) begin
      mf[i].delete();
      mdout[i] = '0;
    end
    exp_a.delete();
    exp_b.delete();
    a_enable = 4'hF;
    b_enable = 3'h7;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    refresh();
    RST = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    chk("drain_a_left", exp_a.size(), 0);
    chk("drain_b_left", exp_b.size(), 0);
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < 6; i++) tick();
  endtask

  // Monitor: scoreboard pops plus read-rule checks, both sampled on the falling edge.
  int a_out = 0;
  int b_out = 0;
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        a_out = 0;
        b_out = 0;
      end else begin
        if (a_rd != 0) begin
          chk("a_rd_to_empty", a_rd & a_empty, 0);
          chk("a_rd_onehot", $countones(a_rd), 1);
          chk("a_credit", (a_out + 1 - int'(a_valid && a_ready)) <= 2, 1);
        end
        if (a_valid && a_ready) begin
          if (exp_a.size() == 0) chk("a_unexpected_word", {a_qid, a_last, a_data}, 0);
          else begin
            e = exp_a.pop_front();
            chk("a_word", {21'd0, a_qid, a_last, a_data}, {21'd0, e});
          end
        end
        a_out = a_out + int'(a_rd != 0) - int'(a_valid && a_ready);
        if (b_rd != 0) begin
          chk("b_rd_to_empty", b_rd & b_empty, 0);
          chk("b_rd_onehot", $countones(b_rd), 1);
          chk("b_credit", (b_out + 1 - int'(b_valid && b_ready)) <= 2, 1);
        end
        if (b_valid && b_ready) begin
          if (exp_b.size() == 0) chk("b_unexpected_word", {b_qid, b_last, b_data}, 0);
          else begin
            e = exp_b.pop_front();
            chk("b_word", {21'd0, b_qid, b_last, b_data}, {21'd0, e});
          end
        end
        b_out = b_out + int'(b_rd != 0) - int'(b_valid && b_ready);
      end
    end
  end

  initial begin
    int nrd, first_rd, last_rd, first_vld, k;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    RST = 1'b1;
    a_enable = 4'hF; b_enable = 3'h7;
    a_ready = 1'b1;  b_ready = 1'b1;
    for (int i = 0; i < 7; i++) mdout[i] = '0;
    refresh();
    do_reset(1'b1);

    // Single 3-word frame on queue 0.
    mf[0].push_back(9'h001); mf[0].push_back(9'h002); mf[0].push_back(9'h1FF);
    exp_a.push_back(11'h001); exp_a.push_back(11'h002); exp_a.push_back(11'h1FF);
    refresh();
    nrd = 0; first_rd = -1; last_rd = -1; first_vld = -1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cap_a_rd[0]) begin
        nrd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (cap_a_vld && first_vld < 0) first_vld = cyc;
    end
    chk("t1_read_count", nrd, 3);
    chk("t1_read_span", last_rd - first_rd, 2);
    chk("t1_latency", first_vld - first_rd, 2);
    chk("t1_busy_end", cap_a_busy, 0);
    chk("t1_left", exp_a.size(), 0);

    // Round robin over four queues, two 2-word frames each.
    do_reset(1'b0);
    for (int f = 0; f < 2; f++)
      for (int q = 0; q < 4; q++)
        frame(0, q, 2, 8'(q*16 + f*4), 1'b1);
    drain(100);

    // Backpressure on a 6-word frame.
    do_reset(1'b0);
    frame(0, 0, 6, 8'h40, 1'b1);
    k = 0;
    while (exp_a.size() != 0 && k < 100) begin
      a_ready = pat[k % 6];
      tick();
      k++;
    end
    a_ready = 1'b1;
    drain(50);

    // Mid-frame stall and gate close on queue 1.
    do_reset(1'b0);
    mf[1].push_back(9'h010); mf[1].push_back(9'h011);
    for (int i = 0; i < 4; i++) exp_a.push_back({2'd1, (i == 3), 8'(8'h10 + i)});
    refresh();
    k = 0;
    while (mf[1].size() != 0 && k < 10) begin
      tick();
      k++;
    end
    chk("t4_q1_drained", mf[1].size(), 0);
    a_enable[1] = 1'b0;
    frame(0, 2, 2, 8'h20, 1'b1);
    frame(0, 0, 2, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_no_rd", cap_a_rd, 0);
      chk("t4_stall_busy", cap_a_busy, 1);
    end
    mf[1].push_back(9'h012); mf[1].push_back(9'h113);
    mf[1].push_back(9'h114);
    refresh();
    drain(100);

    // Reset with two words buffered, then arbitration restarts from queue 0.
    do_reset(1'b0);
    a_ready = 1'b0;
    frame(0, 2, 6, 8'h60, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_buffered_vld", a_valid, 1);
    chk("t5_busy_before", a_busy, 1);
    do_reset(1'b1);
    frame(0, 1, 2, 8'h70, 1'b1);
    frame(0, 3, 2, 8'h80, 1'b1);
    drain(60);

    // Three-queue instance: pointer wraps 2 -> 0.
    do_reset(1'b0);
    frame(1, 0, 2, 8'hA0, 1'b1);
    frame(1, 1, 2, 8'hA4, 1'b1);
    frame(1, 2, 2, 8'hA8, 1'b1);
    drain(60);
    frame(1, 0, 1, 8'hB0, 1'b1);
    drain(30);
    frame(1, 1, 1, 8'hC0, 1'b1);
    frame(1, 2, 1, 8'hC8, 1'b1);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
